// File: rtl/rob_wide_pkg.sv
// Shared types and sizing for the wide reorder buffer.
package rob_pkg;
  localparam int ROB_SIZE      = 32;
  localparam int ROB_IDX_BITS  = 5;
  localparam int PHYS_REG_BITS = 6;
  localparam int DISP_W        = 2;
  localparam int CMT_W         = 2;
  localparam int CPL_PORTS     = 2;

  typedef logic [ROB_IDX_BITS-1:0]  rob_idx_t;
  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  typedef logic [ROB_IDX_BITS:0]    rob_ptr_t;
  typedef logic [PHYS_REG_BITS-1:0] phys_tag_t;
  typedef logic [4:0]               arch_reg_t;

  // Strip the wrap bit to get the storage slot.
  function automatic rob_idx_t ptr_idx(input rob_ptr_t p);
    return p[ROB_IDX_BITS-1:0];
  endfunction
endpackage

// File: rtl/rob_wide_if.sv
// Dispatch / writeback / retire bundle of the reorder buffer.
// Handshake: alloc_req lanes are taken only in a cycle where alloc_ready is high
// (otherwise dropped); commit lanes with commit_valid set retire in any cycle where
// commit_ready is high; cpl_valid is a one-cycle strobe with no back-pressure.
interface rob_wide_if;
  import rob_pkg::*;

  logic                           flush_all;
  logic                           squash_en;
  rob_idx_t                       squash_idx;

  logic [DISP_W-1:0]              alloc_req;
  arch_reg_t [DISP_W-1:0]         alloc_rd;
  logic [DISP_W-1:0]              alloc_has_rd;
  phys_tag_t [DISP_W-1:0]         alloc_phys_rd;
  phys_tag_t [DISP_W-1:0]         alloc_old_phys;
  logic [DISP_W-1:0][31:0]        alloc_pc;
  rob_idx_t [DISP_W-1:0]          alloc_idx;
  logic                           alloc_ready;

  logic [CPL_PORTS-1:0]           cpl_valid;
  rob_idx_t [CPL_PORTS-1:0]       cpl_idx;
  logic [CPL_PORTS-1:0][31:0]     cpl_result;
  logic [CPL_PORTS-1:0]           cpl_exc;

  logic [CMT_W-1:0]               commit_valid;
  arch_reg_t [CMT_W-1:0]          commit_rd;
  logic [CMT_W-1:0]               commit_has_rd;
  phys_tag_t [CMT_W-1:0]          commit_phys_rd;
  phys_tag_t [CMT_W-1:0]          commit_old_phys;
  logic [CMT_W-1:0][31:0]         commit_result;
  logic [CMT_W-1:0][31:0]         commit_pc;
  logic                           commit_exc;
  logic                           commit_ready;

  rob_ptr_t                       occupancy;

  modport master (
    output flush_all, squash_en, squash_idx,
    output alloc_req, alloc_rd, alloc_has_rd, alloc_phys_rd, alloc_old_phys, alloc_pc,
    input  alloc_idx, alloc_ready,
    output cpl_valid, cpl_idx, cpl_result, cpl_exc,
    input  commit_valid, commit_rd, commit_has_rd, commit_phys_rd, commit_old_phys,
    input  commit_result, commit_pc, commit_exc,
    output commit_ready,
    input  occupancy
  );

  modport slave (
    input  flush_all, squash_en, squash_idx,
    input  alloc_req, alloc_rd, alloc_has_rd, alloc_phys_rd, alloc_old_phys, alloc_pc,
    output alloc_idx, alloc_ready,
    input  cpl_valid, cpl_idx, cpl_result, cpl_exc,
    output commit_valid, commit_rd, commit_has_rd, commit_phys_rd, commit_old_phys,
    output commit_result, commit_pc, commit_exc,
    input  commit_ready,
    output occupancy
  );
endinterface

// File: rtl/rob_wide_commit_sel.sv
// Picks the contiguous run of retirable head lanes; an excepting entry retires alone in lane 0.
module rob_commit_sel
  import rob_pkg::*;
(
  input  logic [CMT_W-1:0] occ_i,
  input  logic [CMT_W-1:0] done_i,
  input  logic [CMT_W-1:0] exc_i,
  output logic [CMT_W-1:0] commit_valid_o,
  output logic             commit_exc_o
);
  logic chain_ok;

  // Walk lanes in order; any gap or exception stops younger lanes
  always_comb begin
    chain_ok       = 1'b1;
    commit_valid_o = '0;
    for (int i = 0; i < CMT_W; i++) begin
      commit_valid_o[i] = chain_ok && occ_i[i] && done_i[i] && ((i == 0) || !exc_i[i]);
      chain_ok          = commit_valid_o[i] && !exc_i[i];
    end
    commit_exc_o = commit_valid_o[0] && exc_i[0];
  end
endmodule

// File: rtl/rob_wide.sv
// Superscalar reorder buffer: multi-lane allocate, multi-port complete, in-order multi-lane commit,
// partial squash after a mispredicted branch and full flush.
module rob_wide
  import rob_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  rob_wide_if.slave rob
);
  rob_ptr_t             head_q, head_d, tail_q, tail_d;
  logic                 valid_q    [ROB_SIZE];
  logic                 done_q     [ROB_SIZE];
  logic                 exc_q      [ROB_SIZE];
  arch_reg_t            rd_q       [ROB_SIZE];
  logic                 has_rd_q   [ROB_SIZE];
  phys_tag_t            phys_rd_q  [ROB_SIZE];
  phys_tag_t            old_phys_q [ROB_SIZE];
  logic [31:0]          result_q   [ROB_SIZE];
  logic [31:0]          pc_q       [ROB_SIZE];

  rob_ptr_t             occ, n_alloc, n_cmt, sq_tail;
  rob_idx_t             sq_dist;
  rob_idx_t             cmt_idx    [CMT_W];
  logic [CMT_W-1:0]     lane_occ, lane_done, lane_exc, cmt_valid;
  logic                 cmt_exc, alloc_fire;
  logic [ROB_SIZE-1:0]  kill;
  logic [CPL_PORTS-1:0] cpl_take;

  assign occ             = tail_q - head_q;
  assign rob.occupancy   = occ;
  assign rob.alloc_ready = (occ <= rob_ptr_t'(ROB_SIZE - DISP_W));
  // Squash and flush outrank allocation, so a same-cycle dispatch is discarded.
  assign alloc_fire      = rob.alloc_ready && !rob.flush_all && !rob.squash_en;

  // Allocation slot per lane and number of lanes consumed
  always_comb begin
    n_alloc = '0;
    for (int l = 0; l < DISP_W; l++) begin
      rob.alloc_idx[l] = ptr_idx(tail_q) + rob_idx_t'(l);
      if (rob.alloc_req[l]) n_alloc = n_alloc + rob_ptr_t'(1);
    end
  end

  // Head-side view of the oldest entries, straight from stored state
  always_comb begin
    for (int i = 0; i < CMT_W; i++) begin
      cmt_idx[i]              = ptr_idx(head_q) + rob_idx_t'(i);
      lane_occ[i]             = valid_q[cmt_idx[i]];
      lane_done[i]            = done_q[cmt_idx[i]];
      lane_exc[i]             = exc_q[cmt_idx[i]];
      rob.commit_rd[i]        = rd_q[cmt_idx[i]];
      rob.commit_has_rd[i]    = has_rd_q[cmt_idx[i]];
      rob.commit_phys_rd[i]   = phys_rd_q[cmt_idx[i]];
      rob.commit_old_phys[i]  = old_phys_q[cmt_idx[i]];
      rob.commit_result[i]    = result_q[cmt_idx[i]];
      rob.commit_pc[i]        = pc_q[cmt_idx[i]];
    end
  end

  rob_commit_sel u_commit_sel (
    .occ_i          (lane_occ),
    .done_i         (lane_done),
    .exc_i          (lane_exc),
    .commit_valid_o (cmt_valid),
    .commit_exc_o   (cmt_exc)
  );

  assign rob.commit_valid = cmt_valid;
  assign rob.commit_exc   = cmt_exc;

  // Number of lanes retiring this cycle (valid lanes are contiguous from 0)
  always_comb begin
    n_cmt = '0;
    for (int i = 0; i < CMT_W; i++)
      if (cmt_valid[i]) n_cmt = n_cmt + rob_ptr_t'(1);
  end

  // Squash window: distance of the surviving entry from head sets the new tail,
  // which keeps the wrap bit right no matter where squash_idx sits in storage.
  assign sq_dist = rob.squash_idx - ptr_idx(head_q);
  assign sq_tail = head_q + {1'b0, sq_dist} + rob_ptr_t'(1);

  // Entries strictly younger than squash_idx are discarded
  always_comb begin
    for (int j = 0; j < ROB_SIZE; j++)
      kill[j] = rob.squash_en && ((rob_idx_t'(j) - ptr_idx(head_q)) > sq_dist);
  end

  // A completion lands only on a live entry that is not being squashed
  always_comb begin
    for (int p = 0; p < CPL_PORTS; p++)
      cpl_take[p] = rob.cpl_valid[p] && valid_q[rob.cpl_idx[p]] && !kill[rob.cpl_idx[p]];
  end

  // Next head/tail: flush > squash > alloc on tail; commit independent on head
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (rob.flush_all) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (rob.commit_ready) head_d = head_q + n_cmt;
      if (rob.squash_en)    tail_d = sq_tail;
      else if (alloc_fire)  tail_d = tail_q + n_alloc;
    end
  end

  // Pointers and per-entry status bits; lower completion port written last so it wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int j = 0; j < ROB_SIZE; j++) begin
        valid_q[j] <= 1'b0;
        done_q[j]  <= 1'b0;
        exc_q[j]   <= 1'b0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (rob.flush_all) begin
        for (int j = 0; j < ROB_SIZE; j++) begin
          valid_q[j] <= 1'b0;
          done_q[j]  <= 1'b0;
          exc_q[j]   <= 1'b0;
        end
      end else begin
        for (int p = CPL_PORTS - 1; p >= 0; p--) begin
          if (cpl_take[p]) begin
            done_q[rob.cpl_idx[p]] <= 1'b1;
            exc_q[rob.cpl_idx[p]]  <= rob.cpl_exc[p];
          end
        end
        if (rob.commit_ready) begin
          for (int i = 0; i < CMT_W; i++) begin
            if (cmt_valid[i]) begin
              valid_q[cmt_idx[i]] <= 1'b0;
              done_q[cmt_idx[i]]  <= 1'b0;
              exc_q[cmt_idx[i]]   <= 1'b0;
            end
          end
        end
        for (int j = 0; j < ROB_SIZE; j++) begin
          if (kill[j]) begin
            valid_q[j] <= 1'b0;
            done_q[j]  <= 1'b0;
            exc_q[j]   <= 1'b0;
          end
        end
        if (alloc_fire) begin
          for (int l = 0; l < DISP_W; l++) begin
            if (rob.alloc_req[l]) begin
              valid_q[rob.alloc_idx[l]] <= 1'b1;
              done_q[rob.alloc_idx[l]]  <= 1'b0;
              exc_q[rob.alloc_idx[l]]   <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Entry payload; meaningless while the entry is invalid, so no reset needed
  always_ff @(posedge clk) begin
    for (int p = CPL_PORTS - 1; p >= 0; p--)
      if (cpl_take[p]) result_q[rob.cpl_idx[p]] <= rob.cpl_result[p];
    if (alloc_fire) begin
      for (int l = 0; l < DISP_W; l++) begin
        if (rob.alloc_req[l]) begin
          rd_q[rob.alloc_idx[l]]       <= rob.alloc_rd[l];
          has_rd_q[rob.alloc_idx[l]]   <= rob.alloc_has_rd[l];
          phys_rd_q[rob.alloc_idx[l]]  <= rob.alloc_phys_rd[l];
          old_phys_q[rob.alloc_idx[l]] <= rob.alloc_old_phys[l];
          pc_q[rob.alloc_idx[l]]       <= rob.alloc_pc[l];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_wide.sv
// Directed bench for rob_wide: reset, fill, pair commit, exceptions, wrap and squash.
module tb_rob_wide;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  rob_wide_if bus ();

  rob_wide dut (
    .clk (clk),
    .rst (rst),
    .rob (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_all      = 1'b0;
    bus.squash_en      = 1'b0;
    bus.squash_idx     = '0;
    bus.alloc_req      = '0;
    bus.alloc_rd       = '0;
    bus.alloc_has_rd   = '0;
    bus.alloc_phys_rd  = '0;
    bus.alloc_old_phys = '0;
    bus.alloc_pc       = '0;
    bus.cpl_valid      = '0;
    bus.cpl_idx        = '0;
    bus.cpl_result     = '0;
    bus.cpl_exc        = '0;
    bus.commit_ready   = 1'b0;
  endtask

  // Entry tag t carries rd=t, phys=t+1, old_phys=t+33, pc=0x1000+4t
  task automatic drive_alloc(input logic [1:0] req, input int base);
    bus.alloc_req = req;
    for (int l = 0; l < DISP_W; l++) begin
      bus.alloc_rd[l]       = 5'(base + l);
      bus.alloc_has_rd[l]   = 1'b1;
      bus.alloc_phys_rd[l]  = 6'(base + l + 1);
      bus.alloc_old_phys[l] = 6'(base + l + 33);
      bus.alloc_pc[l]       = 32'h1000 + 32'(4 * (base + l));
    end
  endtask

  task automatic drive_cpl(input int port, input int idx, input logic exc);
    bus.cpl_valid[port]  = 1'b1;
    bus.cpl_idx[port]    = 5'(idx);
    bus.cpl_result[port] = 32'hC000_0000 + 32'(idx);
    bus.cpl_exc[port]    = exc;
  endtask

  task automatic cpl2(input int a, input int b);
    drive_cpl(0, a, 1'b0);
    drive_cpl(1, b, 1'b0);
    tick();
    idle();
  endtask

  task automatic commit_one();
    bus.commit_ready = 1'b1;
    tick();
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%b exp=1", bus.alloc_ready); end
    checks++; if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL reset_commit_valid got=%b exp=00", bus.commit_valid); end
    checks++; if (bus.commit_exc !== 1'b0) begin failures++; $display("FAIL reset_commit_exc got=%b exp=0", bus.commit_exc); end
    #2 rst = 1'b0;
  endtask

  task automatic test_reset_mid_traffic();
    tick();
    for (int k = 0; k < 5; k++) begin
      drive_alloc(2'b11, 2 * k);
      tick();
      idle();
    end
    cpl2(0, 1);
    #1;
    checks++; if (bus.occupancy !== 6'd10) begin failures++; $display("FAIL midrst_occ_before got=%0d exp=10", bus.occupancy); end
    checks++; if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL midrst_cv_before got=%b exp=11", bus.commit_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL midrst_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL midrst_cv got=%b exp=00", bus.commit_valid); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL midrst_alloc_ready got=%b exp=1", bus.alloc_ready); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int k = 0; k < 16; k++) begin
      drive_alloc(2'b11, 2 * k);
      #1;
      checks++;
      if (bus.alloc_idx !== {5'(2 * k + 1), 5'(2 * k)}) begin
        failures++; $display("FAIL fill_idx k=%0d got=%h exp=%h", k, bus.alloc_idx, {5'(2 * k + 1), 5'(2 * k)});
      end
      tick();
      idle();
    end
    #1;
    checks++; if (bus.occupancy !== 6'd32) begin failures++; $display("FAIL fill_occ got=%0d exp=32", bus.occupancy); end
    checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_alloc_ready got=%b exp=0", bus.alloc_ready); end
    drive_alloc(2'b11, 40);
    tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 6'd32) begin failures++; $display("FAIL fill_drop_occ got=%0d exp=32", bus.occupancy); end
    checks++; if (bus.alloc_idx[0] !== 5'd0) begin failures++; $display("FAIL fill_drop_tail got=%0d exp=0", bus.alloc_idx[0]); end
  endtask

  task automatic test_commit_pair();
    drive_cpl(0, 1, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL pair_cv_idx1_only got=%b exp=00", bus.commit_valid); end
    drive_cpl(1, 0, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL pair_cv got=%b exp=11", bus.commit_valid); end
    checks++; if (bus.commit_old_phys[0] !== 6'd33) begin failures++; $display("FAIL pair_old0 got=%0d exp=33", bus.commit_old_phys[0]); end
    checks++; if (bus.commit_old_phys[1] !== 6'd34) begin failures++; $display("FAIL pair_old1 got=%0d exp=34", bus.commit_old_phys[1]); end
    checks++; if (bus.commit_phys_rd[1] !== 6'd2) begin failures++; $display("FAIL pair_phys1 got=%0d exp=2", bus.commit_phys_rd[1]); end
    checks++; if (bus.commit_rd[1] !== 5'd1) begin failures++; $display("FAIL pair_rd1 got=%0d exp=1", bus.commit_rd[1]); end
    checks++; if (bus.commit_result[0] !== 32'hC000_0000) begin failures++; $display("FAIL pair_result0 got=%h exp=c0000000", bus.commit_result[0]); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd30) begin failures++; $display("FAIL pair_occ got=%0d exp=30", bus.occupancy); end
    checks++; if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL pair_cv_after got=%b exp=00", bus.commit_valid); end
    checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL pair_alloc_ready got=%b exp=1", bus.alloc_ready); end
  endtask

  task automatic test_flush();
    bus.flush_all = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.commit_valid !== 2'b00) begin failures++; $display("FAIL flush_cv got=%b exp=00", bus.commit_valid); end
  endtask

  task automatic test_exception();
    drive_alloc(2'b11, 0);
    #1;
    checks++; if (bus.alloc_idx[0] !== 5'd0) begin failures++; $display("FAIL exc_first_idx got=%0d exp=0", bus.alloc_idx[0]); end
    tick();
    idle();
    drive_alloc(2'b11, 2);
    tick();
    idle();
    drive_cpl(0, 0, 1'b0);
    drive_cpl(1, 1, 1'b1);
    tick();
    idle();
    cpl2(2, 3);
    #1;
    checks++; if (bus.commit_valid !== 2'b01) begin failures++; $display("FAIL exc_c1_cv got=%b exp=01", bus.commit_valid); end
    checks++; if (bus.commit_exc !== 1'b0) begin failures++; $display("FAIL exc_c1_exc got=%b exp=0", bus.commit_exc); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd3) begin failures++; $display("FAIL exc_c2_occ got=%0d exp=3", bus.occupancy); end
    checks++; if (bus.commit_valid !== 2'b01) begin failures++; $display("FAIL exc_c2_cv got=%b exp=01", bus.commit_valid); end
    checks++; if (bus.commit_exc !== 1'b1) begin failures++; $display("FAIL exc_c2_exc got=%b exp=1", bus.commit_exc); end
    checks++; if (bus.commit_pc[0] !== 32'h1004) begin failures++; $display("FAIL exc_c2_pc got=%h exp=1004", bus.commit_pc[0]); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd2) begin failures++; $display("FAIL exc_c3_occ got=%0d exp=2", bus.occupancy); end
    checks++; if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL exc_c3_cv got=%b exp=11", bus.commit_valid); end
    checks++; if (bus.commit_exc !== 1'b0) begin failures++; $display("FAIL exc_c3_exc got=%b exp=0", bus.commit_exc); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL exc_c4_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_wrap();
    bus.flush_all = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 15; k++) begin
      drive_alloc(2'b11, 2 * k);
      tick();
      idle();
    end
    for (int k = 0; k < 15; k++) cpl2(2 * k, 2 * k + 1);
    #1;
    checks++; if (bus.occupancy !== 6'd30) begin failures++; $display("FAIL wrap_prefill_occ got=%0d exp=30", bus.occupancy); end
    bus.commit_ready = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL wrap_drain_occ got=%0d exp=0", bus.occupancy); end
    drive_alloc(2'b11, 30);
    #1;
    checks++; if (bus.alloc_idx !== {5'd31, 5'd30}) begin failures++; $display("FAIL wrap_idx_a got=%h exp=%h", bus.alloc_idx, {5'd31, 5'd30}); end
    tick();
    idle();
    drive_alloc(2'b11, 0);
    #1;
    checks++; if (bus.alloc_idx !== {5'd1, 5'd0}) begin failures++; $display("FAIL wrap_idx_b got=%h exp=%h", bus.alloc_idx, {5'd1, 5'd0}); end
    tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 6'd4) begin failures++; $display("FAIL wrap_occ4 got=%0d exp=4", bus.occupancy); end
    cpl2(30, 31);
    cpl2(0, 1);
    #1;
    checks++; if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL wrap_cv got=%b exp=11", bus.commit_valid); end
    checks++; if (bus.commit_pc[1] !== 32'h107C) begin failures++; $display("FAIL wrap_pc31 got=%h exp=107c", bus.commit_pc[1]); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd2) begin failures++; $display("FAIL wrap_occ2 got=%0d exp=2", bus.occupancy); end
    checks++; if (bus.commit_pc[0] !== 32'h1000) begin failures++; $display("FAIL wrap_pc0 got=%h exp=1000", bus.commit_pc[0]); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd0) begin failures++; $display("FAIL wrap_occ0 got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_squash();
    // head is slot 2 here; fill slots 2..9
    for (int k = 0; k < 4; k++) begin
      drive_alloc(2'b11, 2 + 2 * k);
      tick();
      idle();
    end
    #1;
    checks++; if (bus.occupancy !== 6'd8) begin failures++; $display("FAIL sq_occ8 got=%0d exp=8", bus.occupancy); end
    bus.squash_en  = 1'b1;
    bus.squash_idx = 5'd4;
    drive_alloc(2'b11, 20);
    drive_cpl(0, 7, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 6'd3) begin failures++; $display("FAIL sq_occ3 got=%0d exp=3", bus.occupancy); end
    drive_alloc(2'b11, 5);
    #1;
    checks++; if (bus.alloc_idx !== {5'd6, 5'd5}) begin failures++; $display("FAIL sq_new_tail got=%h exp=%h", bus.alloc_idx, {5'd6, 5'd5}); end
    tick();
    idle();
    drive_alloc(2'b11, 7);
    tick();
    idle();
    #1;
    checks++; if (bus.occupancy !== 6'd7) begin failures++; $display("FAIL sq_occ7 got=%0d exp=7", bus.occupancy); end
    cpl2(2, 3);
    #1;
    checks++; if (bus.commit_valid !== 2'b11) begin failures++; $display("FAIL sq_cv23 got=%b exp=11", bus.commit_valid); end
    commit_one();
    cpl2(4, 5);
    commit_one();
    drive_cpl(0, 6, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (bus.commit_valid !== 2'b01) begin failures++; $display("FAIL sq_cv67 got=%b exp=01", bus.commit_valid); end
    checks++; if (bus.commit_pc[0] !== 32'h1018) begin failures++; $display("FAIL sq_pc6 got=%h exp=1018", bus.commit_pc[0]); end
    commit_one();
    #1;
    checks++; if (bus.occupancy !== 6'd2) begin failures++; $display("FAIL sq_occ_end got=%0d exp=2", bus.occupancy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_fill();
    test_commit_pair();
    test_flush();
    test_exception();
    test_wrap();
    test_squash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
